ecg_group_sequencer: RTL



---
 rtl/ecg_group_sequencer_pkg.sv | 19 +
 rtl/ecg_group_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/ecg_group_sequencer_pkg.sv
// Shared constants and state encoding for the ECG group sequencer.
// A block is scanned component-major, ECG-minor.
package ecg_group_sequencer_pkg;

    localparam int NUM_COMP    = 3;
    localparam int NUM_ECG     = 4;
    localparam int GRP_PER_BLK = NUM_COMP * NUM_ECG;

    localparam logic [1:0] LAST_COMP = 2'(NUM_COMP - 1);
    localparam logic [1:0] LAST_ECG  = 2'(NUM_ECG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ecg_group_sequencer.sv
// Walks the 12 (component, ECG) groups of a block, asks the external DataActive
// decoder which are active, and offers each active group downstream with a handshake.
module ecg_group_sequencer
    import ecg_group_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sub_sample_info,
    input  logic [2:0] component_skip,
    input  logic       data_active,
    output logic [1:0] ecgidx,
    output logic [1:0] component_idx,
    output logic [1:0] ss_info_out,
    output logic       comp_skip_sel,
    output logic       grp_valid,
    input  logic       grp_ready,
    output logic [3:0] grp_seq,
    output logic       busy,
    output logic       done,
    output logic [3:0] active_cnt
);

    state_e     state_q;
    logic [1:0] ecg_q, comp_q, ss_q;
    logic [2:0] skip_q;
    logic [3:0] seq_q, act_cnt_q;
    logic       valid_q, busy_q, done_q;

    logic [1:0] ecg_d, comp_d;
    logic       last_grp;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        ecg_d    = ecg_q + 2'd1;
        comp_d   = comp_q;
        last_grp = (comp_q == LAST_COMP) && (ecg_q == LAST_ECG);
        if (ecg_q == LAST_ECG) begin
            ecg_d  = 2'd0;
            comp_d = comp_q + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ecg_q     <= '0;
            comp_q    <= '0;
            ss_q      <= '0;
            skip_q    <= '0;
            seq_q     <= '0;
            act_cnt_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SCAN;
                        busy_q  <= 1'b1;
                        ecg_q   <= '0;
                        comp_q  <= '0;
                        seq_q   <= '0;
                        ss_q    <= sub_sample_info;
                        skip_q  <= component_skip;
                    end
                end
                ST_SCAN: begin
                    if (data_active) begin
                        state_q <= ST_EMIT;
                        valid_q <= 1'b1;
                    end else if (last_grp) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        act_cnt_q <= seq_q;
                    end else begin
                        ecg_q  <= ecg_d;
                        comp_q <= comp_d;
                    end
                end
                ST_EMIT: begin
                    if (grp_ready) begin
                        valid_q <= 1'b0;
                        seq_q   <= seq_q + 4'd1;
                        if (last_grp) begin
                            // Indices stay at the last group rather than wrapping out of range.
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            act_cnt_q <= seq_q + 4'd1;
                        end else begin
                            state_q <= ST_SCAN;
                            ecg_q   <= ecg_d;
                            comp_q  <= comp_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ecgidx        = ecg_q;
    assign component_idx = comp_q;
    assign ss_info_out   = ss_q;
    assign comp_skip_sel = skip_q[comp_q];
    assign grp_valid     = valid_q;
    assign grp_seq       = seq_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign active_cnt    = act_cnt_q;

endmodule
